// File: rtl/tenbaset_pkg.sv
// tenbaset_pkg
// Shared constants for the 10BASE-T beacon transmitter:
//   - frame geometry (FRAME_BYTES, PREAMBLE_NIBBLES, SFD_NIBBLE)
//   - the fixed 60-byte broadcast frame ROM (byte 0 first)
//   - CRC-32 polynomial/init and a nibble-step CRC helper
//   - FRAME_FCS, the FCS of the ROM, folded at elaboration time so the
//     default build (TENBASET_CRC_EN undefined) carries no CRC hardware
//   - the transmitter state enum
package tenbaset_pkg;

    localparam int          FRAME_BYTES      = 60;
    localparam int          PREAMBLE_NIBBLES = 15;
    localparam int          FCS_NIBBLES      = 8;
    localparam logic [3:0]  PREAMBLE_NIBBLE  = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE       = 4'hD;
    localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_PHY_RST  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_SFD      = 3'd3,
        ST_DATA     = 3'd4,
        ST_FCS      = 3'd5
    } state_t;

    // Index 0 is the first byte on the wire.
    // 14-33: IPv4 header, 10 -> 192.168.1.100 -> 255.255.255.255, UDP,
    //        total length 46, header checksum 0x78B3.
    // 34-41: UDP 1234 -> 1234, length 26, checksum unused (0).
    // 42-59: payload "TENBASET BEACON 01".
    localparam logic [0:FRAME_BYTES-1][7:0] FRAME_ROM = {
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h90,
        8'h08, 8'h00,
        8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00,
        8'h40, 8'h11, 8'h78, 8'hB3, 8'hC0, 8'hA8, 8'h01, 8'h64,
        8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h04, 8'hD2, 8'h04, 8'hD2, 8'h00, 8'h1A, 8'h00, 8'h00,
        8'h54, 8'h45, 8'h4E, 8'h42, 8'h41, 8'h53, 8'h45, 8'h54,
        8'h20, 8'h42, 8'h45, 8'h41, 8'h43, 8'h4F, 8'h4E, 8'h20,
        8'h30, 8'h31
    };

    // One nibble through the reflected CRC-32, LSB of the nibble first,
    // which is the order the bits leave the PHY.
    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc,
                                                 input logic [3:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] frame_fcs_calc();
        logic [31:0] c;
        c = CRC_INIT;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            c = crc32_nibble(c, FRAME_ROM[i][3:0]);
            c = crc32_nibble(c, FRAME_ROM[i][7:4]);
        end
        return ~c;
    endfunction

    // Complemented CRC of the ROM; bits [7:0] are the first FCS byte.
    localparam logic [31:0] FRAME_FCS = frame_fcs_calc();

endpackage

// File: rtl/tenbaset_crc32.sv
// tenbaset_crc32
// Nibble-wide Ethernet CRC-32 (reflected, init all-ones).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   init       : load the register with all-ones (has priority over en)
//   en         : absorb one nibble from data
//   data[3:0]  : nibble in wire order (bit 0 transmitted first)
//   fcs[31:0]  : complemented register, ready to transmit low byte first
module tenbaset_crc32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  data,
    output logic [31:0] fcs
);
    import tenbaset_pkg::*;

    logic [31:0] crc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     crc <= CRC_INIT;
        else if (init) crc <= CRC_INIT;
        else if (en)   crc <= crc32_nibble(crc, data);
    end

    assign fcs = ~crc;

endmodule

// File: rtl/tenbaset_txd.sv
// tenbaset_txd
// Free-running 10 Mb/s Ethernet beacon: holds the PHY in reset after
// reset, then sends one fixed 60-byte broadcast frame (preamble, SFD,
// data, FCS) over MII TXD/TX_EN, separated by GAP_NIBBLES idle nibbles.
// Build option: TENBASET_CRC_EN defined -> FCS from a live nibble CRC
// engine; undefined -> FCS from the package constant FRAME_FCS.
// Ports:
//   clk       : system clock (CLK_DIV clocks per MII nibble)
//   reset     : asynchronous active-high reset
//   out[3:0]  : MII TXD[3:0]
//   ctrl      : MII TX_EN
//   phy_reset : PHY reset, active-low (0 holds the PHY in reset)
//   TXD4      : TXD[4]/TX_ER, tied 0
module tenbaset_txd #(
    parameter int CLK_DIV        = 40,
    parameter int PHY_RST_CYCLES = 1000,
    parameter int GAP_NIBBLES    = 2500
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] out,
    output logic       ctrl,
    output logic       phy_reset,
    output logic       TXD4
);
    import tenbaset_pkg::*;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = (PHY_RST_CYCLES > 1) ? $clog2(PHY_RST_CYCLES) : 1;
    localparam int GAP_W = $clog2(GAP_NIBBLES + 1);

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt;
    logic             strobe;
    logic [RST_W-1:0] rst_cnt, rst_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [3:0]       nib_cnt, nib_cnt_n;
    logic [5:0]       byte_idx, byte_idx_n;
    logic             nib_sel, nib_sel_n;
    logic             phy_rel;
    logic [3:0]       out_d;
    logic             ctrl_d;
    logic [7:0]       rom_byte;
    logic [31:0]      fcs;

    assign TXD4 = 1'b0;

    // The divider is parked while the PHY is in reset, so the first idle
    // gap starts on a nibble boundary aligned to phy_reset release.
    assign strobe = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    div_cnt <= '0;
        else if (state == ST_PHY_RST) div_cnt <= '0;
        else if (strobe)              div_cnt <= '0;
        else                          div_cnt <= div_cnt + DIV_W'(1);
    end

`ifdef TENBASET_CRC_EN
    logic crc_init;
    logic crc_en;

    // The engine absorbs each data nibble as it is loaded into the output
    // register, so the register is final by the time FCS nibble 0 loads.
    assign crc_init = (state == ST_IDLE);
    assign crc_en   = strobe && (state_n == ST_DATA);

    tenbaset_crc32 u_crc32 (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .data  (out_d),
        .fcs   (fcs)
    );
`else
    assign fcs = FRAME_FCS;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_PHY_RST;
            rst_cnt   <= '0;
            gap_cnt   <= '0;
            nib_cnt   <= '0;
            byte_idx  <= '0;
            nib_sel   <= 1'b0;
            phy_reset <= 1'b0;
            out       <= 4'h0;
            ctrl      <= 1'b0;
        end else begin
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            gap_cnt   <= gap_cnt_n;
            nib_cnt   <= nib_cnt_n;
            byte_idx  <= byte_idx_n;
            nib_sel   <= nib_sel_n;
            phy_reset <= phy_rel;
            out       <= out_d;
            ctrl      <= ctrl_d;
        end
    end

    // Next state. The registered state describes the nibble currently on
    // the wire; every transition outside PHY_RST happens on a strobe.
    always_comb begin
        state_n    = state;
        rst_cnt_n  = rst_cnt;
        gap_cnt_n  = gap_cnt;
        nib_cnt_n  = nib_cnt;
        byte_idx_n = byte_idx;
        nib_sel_n  = nib_sel;
        phy_rel    = phy_reset;
        case (state)
            ST_PHY_RST: begin
                if (rst_cnt == RST_W'(PHY_RST_CYCLES - 1)) begin
                    state_n   = ST_IDLE;
                    gap_cnt_n = GAP_W'(GAP_NIBBLES);
                    phy_rel   = 1'b1;
                end else begin
                    rst_cnt_n = rst_cnt + RST_W'(1);
                end
            end
            ST_IDLE: begin
                if (strobe) begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state_n   = ST_PREAMBLE;
                        nib_cnt_n = 4'd0;
                    end else begin
                        gap_cnt_n = gap_cnt - GAP_W'(1);
                    end
                end
            end
            ST_PREAMBLE: begin
                if (strobe) begin
                    if (nib_cnt == 4'(PREAMBLE_NIBBLES - 1)) state_n = ST_SFD;
                    else nib_cnt_n = nib_cnt + 4'd1;
                end
            end
            ST_SFD: begin
                if (strobe) begin
                    state_n    = ST_DATA;
                    byte_idx_n = 6'd0;
                    nib_sel_n  = 1'b0;
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    if (!nib_sel) begin
                        nib_sel_n = 1'b1;
                    end else if (byte_idx == 6'(FRAME_BYTES - 1)) begin
                        state_n   = ST_FCS;
                        nib_cnt_n = 4'd0;
                    end else begin
                        byte_idx_n = byte_idx + 6'd1;
                        nib_sel_n  = 1'b0;
                    end
                end
            end
            ST_FCS: begin
                if (strobe) begin
                    if (nib_cnt == 4'(FCS_NIBBLES - 1)) begin
                        state_n   = ST_IDLE;
                        gap_cnt_n = GAP_W'(GAP_NIBBLES);
                    end else begin
                        nib_cnt_n = nib_cnt + 4'd1;
                    end
                end
            end
            default: state_n = ST_PHY_RST;
        endcase
    end

    // Output decode from the next-state values, so out/ctrl are registered
    // and move on exactly the clock edge that consumes a strobe.
    always_comb begin
        out_d    = 4'h0;
        ctrl_d   = 1'b0;
        rom_byte = FRAME_ROM[byte_idx_n];
        case (state_n)
            ST_PREAMBLE: begin
                out_d  = PREAMBLE_NIBBLE;
                ctrl_d = 1'b1;
            end
            ST_SFD: begin
                out_d  = SFD_NIBBLE;
                ctrl_d = 1'b1;
            end
            ST_DATA: begin
                out_d  = nib_sel_n ? rom_byte[7:4] : rom_byte[3:0];
                ctrl_d = 1'b1;
            end
            ST_FCS: begin
                out_d  = fcs[{nib_cnt_n[2:0], 2'b00} +: 4];
                ctrl_d = 1'b1;
            end
            default: begin
                out_d  = 4'h0;
                ctrl_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tenbaset_txd.sv
// tb_tenbaset_txd
// Directed bench for tenbaset_txd with CLK_DIV=4, PHY_RST_CYCLES=10,
// GAP_NIBBLES=24. Works unchanged with or without TENBASET_CRC_EN.
module tb_tenbaset_txd;

    localparam int CLK_DIV = 4;
    localparam int PHY_RST = 10;
    localparam int GAP     = 24;
    localparam int FRAME_NIBS = 144;

    // First 28 data nibbles: dest FF.., src 00:12:34:56:78:90, type 0800,
    // each byte low nibble first.
    localparam logic [0:27][3:0] EXP_HDR = 112'hFFFFFFFFFFFF_002143658709_8000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] out;
    logic       ctrl;
    logic       phy_reset;
    logic       TXD4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] cap     [FRAME_NIBS];
    logic [3:0] frame_a [FRAME_NIBS];
    logic [7:0] fb      [64];
    int         cap_lows;
    logic       cap_tail;
    int         rise_a;

    tenbaset_txd #(
        .CLK_DIV        (CLK_DIV),
        .PHY_RST_CYCLES (PHY_RST),
        .GAP_NIBBLES    (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .out       (out),
        .ctrl      (ctrl),
        .phy_reset (phy_reset),
        .TXD4      (TXD4)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t required<500000", $time);
        $fatal(1);
    end

    // ---------------- continuous monitor ----------------
    logic [4:0] mon_prev  = 5'd0;
    logic       mon_valid = 1'b0;
    int         last_chg  = 0;

    always @(posedge clk) begin
        #1;
        total++;
        if (TXD4 !== 1'b0) begin
            bad++;
            $display("FAIL txd4: got %b required 0 at cyc %0d", TXD4, cyc);
        end
        if (reset) begin
            mon_valid = 1'b0;
        end else if ({ctrl, out} !== mon_prev) begin
            if (mon_valid) begin
                total++;
                if (((cyc - last_chg) % CLK_DIV) != 0) begin
                    bad++;
                    $display("FAIL strobe_align: change after %0d clocks, required multiple of %0d",
                             cyc - last_chg, CLK_DIV);
                end
            end
            mon_valid = 1'b1;
            last_chg  = cyc;
        end
        mon_prev = {ctrl, out};
    end

    // ---------------- helpers (no checks inside) ----------------
    task automatic wait_rise(input int limit, output int waited);
        logic prev;
        prev   = ctrl;
        waited = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (ctrl === 1'b1 && prev !== 1'b1) begin
                waited = i;
                break;
            end
            prev = ctrl;
        end
    endtask

    task automatic count_phy_hold(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (phy_reset === 1'b1) break;
        end
    endtask

    // Called on the sample where ctrl has just risen.
    task automatic capture_frame();
        cap_lows = 0;
        cap[0] = out;
        for (int i = 1; i < FRAME_NIBS; i++) begin
            repeat (CLK_DIV) @(posedge clk);
            #1;
            cap[i] = out;
            if (ctrl !== 1'b1) cap_lows++;
        end
        repeat (CLK_DIV) @(posedge clk);
        #1;
        cap_tail = ctrl;
    endtask

    // Plain bit-serial reflected CRC-32 over fb[0..n-1], no final invert.
    function automatic logic [31:0] bench_crc(input int n);
        logic [31:0] c;
        logic        f;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                f = c[0] ^ fb[i][k];
                c = c >> 1;
                if (f) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        int w;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out !== 4'h0)     begin bad++; $display("FAIL rst_out: got %h required 0", out); end
        total++; if (ctrl !== 1'b0)    begin bad++; $display("FAIL rst_ctrl: got %b required 0", ctrl); end
        total++; if (phy_reset !== 1'b0) begin bad++; $display("FAIL rst_phy: got %b required 0", phy_reset); end
        total++; if (TXD4 !== 1'b0)    begin bad++; $display("FAIL rst_txd4: got %b required 0", TXD4); end
        @(negedge clk);
        reset = 1'b0;
        count_phy_hold(n);
        total++;
        if (n !== PHY_RST) begin bad++; $display("FAIL phy_hold: got %0d clocks required %0d", n, PHY_RST); end
        wait_rise(400, w);
        total++;
        if (w !== GAP * CLK_DIV) begin bad++; $display("FAIL first_gap: got %0d clocks required %0d", w, GAP * CLK_DIV); end
        rise_a = cyc;
    endtask

    task automatic test_first_frame();
        logic [31:0] fcs_tx;
        logic [31:0] fcs_calc;
        logic [31:0] resid;
        logic [31:0] resid_rev;
        capture_frame();
        for (int i = 0; i < FRAME_NIBS; i++) frame_a[i] = cap[i];
        total++; if (cap_lows !== 0) begin bad++; $display("FAIL frame_en: %0d low nibbles required 0", cap_lows); end
        total++; if (cap_tail !== 1'b0) begin bad++; $display("FAIL frame_len: ctrl after 144 nibbles %b required 0", cap_tail); end
        for (int i = 0; i < 15; i++) begin
            total++;
            if (frame_a[i] !== 4'h5) begin bad++; $display("FAIL preamble[%0d]: got %h required 5", i, frame_a[i]); end
        end
        total++; if (frame_a[15] !== 4'hD) begin bad++; $display("FAIL sfd: got %h required d", frame_a[15]); end
        for (int i = 0; i < 28; i++) begin
            total++;
            if (frame_a[16 + i] !== EXP_HDR[i]) begin
                bad++; $display("FAIL header[%0d]: got %h required %h", i, frame_a[16 + i], EXP_HDR[i]);
            end
        end
        for (int b = 0; b < 64; b++) fb[b] = {frame_a[16 + 2 * b + 1], frame_a[16 + 2 * b]};
        fcs_tx   = {fb[63], fb[62], fb[61], fb[60]};
        fcs_calc = ~bench_crc(60);
        total++;
        if (fcs_tx !== fcs_calc) begin bad++; $display("FAIL fcs: got %h required %h", fcs_tx, fcs_calc); end
        resid = bench_crc(64);
        for (int i = 0; i < 32; i++) resid_rev[i] = resid[31 - i];
        total++;
        if (resid_rev !== 32'hC704DD7B) begin bad++; $display("FAIL residue: got %h required c704dd7b", resid_rev); end
    endtask

    task automatic test_back_to_back();
        int w;
        int diffs;
        wait_rise(1000, w);
        total++;
        if (cyc - rise_a !== (FRAME_NIBS + GAP) * CLK_DIV) begin
            bad++; $display("FAIL period: got %0d clocks required %0d", cyc - rise_a, (FRAME_NIBS + GAP) * CLK_DIV);
        end
        capture_frame();
        diffs = 0;
        for (int i = 0; i < FRAME_NIBS; i++) if (cap[i] !== frame_a[i]) diffs++;
        total++; if (diffs !== 0) begin bad++; $display("FAIL frame2_same: %0d nibbles differ required 0", diffs); end
        total++; if (cap_lows !== 0) begin bad++; $display("FAIL frame2_en: %0d low nibbles required 0", cap_lows); end
        total++; if (cap_tail !== 1'b0) begin bad++; $display("FAIL frame2_len: ctrl after 144 nibbles %b required 0", cap_tail); end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int n;
        int diffs;
        wait_rise(1000, w);
        // 60 nibbles in: data nibble 44
        repeat (60 * CLK_DIV) @(posedge clk);
        #3;
        total++; if (ctrl !== 1'b1) begin bad++; $display("FAIL mid_active: ctrl %b required 1 before reset", ctrl); end
        reset = 1'b1;
        #1;
        total++; if (ctrl !== 1'b0) begin bad++; $display("FAIL mid_ctrl: got %b required 0", ctrl); end
        total++; if (out !== 4'h0)  begin bad++; $display("FAIL mid_out: got %h required 0", out); end
        total++; if (phy_reset !== 1'b0) begin bad++; $display("FAIL mid_phy: got %b required 0", phy_reset); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_phy_hold(n);
        total++;
        if (n !== PHY_RST) begin bad++; $display("FAIL mid_phy_hold: got %0d clocks required %0d", n, PHY_RST); end
        wait_rise(400, w);
        total++;
        if (w !== GAP * CLK_DIV) begin bad++; $display("FAIL mid_gap: got %0d clocks required %0d", w, GAP * CLK_DIV); end
        capture_frame();
        diffs = 0;
        for (int i = 0; i < FRAME_NIBS; i++) if (cap[i] !== frame_a[i]) diffs++;
        total++; if (diffs !== 0) begin bad++; $display("FAIL mid_frame_same: %0d nibbles differ required 0", diffs); end
        total++; if (cap_tail !== 1'b0) begin bad++; $display("FAIL mid_frame_len: ctrl after 144 nibbles %b required 0", cap_tail); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
